// File: rtl/life_sweep_engine_pkg.sv
// life_pkg: grid geometry, port length codes, sweep FSM states and address helper
package life_pkg;
  localparam int GRID_W = 10;
  localparam int ROW_LO = 1;
  localparam int ROW_HI = 8;
  localparam logic [1:0] BYTEWIDE = 2'b00;
  localparam logic [1:0] HALFWIDE = 2'b01;
  localparam logic [1:0] WORDWIDE = 2'b10;
  typedef enum logic [2:0] {IDLE, READ, WRITE, FLUSH, DONE} state_t;
  function automatic logic [39:0] cell_addr(input logic [3:0] row, input logic [3:0] col);
    return 40'(row) * 40'(GRID_W) + 40'(col);
  endfunction
endpackage

// File: rtl/life_sweep_engine_if.sv
// life_sweep_engine_if: requester-side view of the two-port grid memory
interface life_sweep_engine_if;
  logic [39:0] mem_addr0, mem_addr1, mem_wdata0, mem_wdata1, mem_rdata0, mem_rdata1;
  logic        mem_rden0, mem_rden1, mem_we0, mem_we1, mem_neighbor;
  logic [1:0]  mem_len0, mem_len1;
  modport master (
    output mem_addr0, mem_addr1, mem_rden0, mem_rden1, mem_we0, mem_we1,
           mem_neighbor, mem_len0, mem_len1, mem_wdata0, mem_wdata1,
    input  mem_rdata0, mem_rdata1
  );
  modport slave (
    input  mem_addr0, mem_addr1, mem_rden0, mem_rden1, mem_we0, mem_we1,
           mem_neighbor, mem_len0, mem_len1, mem_wdata0, mem_wdata1,
    output mem_rdata0, mem_rdata1
  );
endinterface

// File: rtl/life_sweep_engine_rule.sv
// life_rule: counts live neighbours in a NeighborMode window and applies birth/survive masks
module life_rule (
  input  logic [79:0] i_window,
  input  logic [8:0]  i_birth_mask,
  input  logic [8:0]  i_survive_mask,
  output logic [7:0]  o_cell
);
  logic [3:0] w_count;
  logic       w_alive;
  always_comb begin
    w_count = '0;
    for (int k = 0; k < 4; k++) w_count = w_count + 4'(i_window[8*k]) + 4'(i_window[40+8*k]);
  end
  // centre byte sits at [39:32] of port 1, i.e. bit 32 of the window
  assign w_alive = i_window[32] ? i_survive_mask[w_count] : i_birth_mask[w_count];
  assign o_cell = {7'd0, w_alive};
endmodule

// File: rtl/life_sweep_engine.sv
// life_sweep_engine: sweeps the 10x10 grid once per start, buffering rows until they stop being neighbours
module life_sweep_engine import life_pkg::*; #(
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [15:0]                 o_gen_count,
  life_sweep_engine_if.master         mem
);
  state_t      r_state, w_next;
  logic [3:0]  r_row, r_col, w_wrow;
  logic [7:0]  r_cur [GRID_W];
  logic [7:0]  r_pend [GRID_W];
  logic [7:0]  w_cur [GRID_W];
  logic [7:0]  w_cell;
  logic [15:0] r_gen;
  logic        w_rd, w_wr;

  life_rule u_rule (
    .i_window       ({mem.mem_rdata0, mem.mem_rdata1}),
    .i_birth_mask   (BIRTH_MASK),
    .i_survive_mask (SURVIVE_MASK),
    .o_cell         (w_cell)
  );

  // row buffer as it will look after this READ edge, edge columns copied verbatim
  always_comb begin
    w_cur = r_cur;
    w_cur[r_col] = w_cell;
    if (r_col == 4'd1) w_cur[0] = mem.mem_rdata1[31:24];
    if (r_col == 4'd8) w_cur[9] = mem.mem_rdata0[7:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start ? READ : IDLE;
      READ:    w_next = (r_col == 4'd8 && r_row != 4'(ROW_LO)) ? WRITE : READ;
      WRITE:   w_next = (r_row == 4'(ROW_HI)) ? FLUSH : READ;
      FLUSH:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_gen   <= '0;
      r_cur   <= '{default: '0};
      r_pend  <= '{default: '0};
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (i_start) begin
          r_row <= 4'(ROW_LO);
          r_col <= 4'd1;
        end
        READ: begin
          r_cur <= w_cur;
          r_col <= (r_col == 4'd8) ? 4'd1 : r_col + 4'd1;
          if (r_col == 4'd8 && r_row == 4'(ROW_LO)) begin
            r_pend <= w_cur;
            r_row  <= r_row + 4'd1;
          end
        end
        WRITE: begin
          r_pend <= r_cur;
          if (r_row != 4'(ROW_HI)) r_row <= r_row + 4'd1;
        end
        DONE: r_gen <= r_gen + 16'd1;
        default: ;
      endcase
    end
  end

  assign w_rd = (r_state == READ);
  assign w_wr = (r_state == WRITE) || (r_state == FLUSH);
  // WRITE trails the read row by one; FLUSH writes the last row itself
  assign w_wrow = (r_state == FLUSH) ? r_row : r_row - 4'd1;

  assign mem.mem_neighbor = w_rd;
  assign mem.mem_rden0    = w_rd;
  assign mem.mem_rden1    = w_rd;
  assign mem.mem_we0      = w_wr;
  assign mem.mem_we1      = w_wr;
  assign mem.mem_len0     = w_wr ? WORDWIDE : BYTEWIDE;
  assign mem.mem_len1     = w_wr ? WORDWIDE : BYTEWIDE;
  assign mem.mem_addr0    = w_rd ? cell_addr(r_row, r_col) : w_wr ? cell_addr(w_wrow, 4'd0) : '0;
  assign mem.mem_addr1    = w_wr ? cell_addr(w_wrow, 4'd5) : '0;
  assign mem.mem_wdata0   = w_wr ? {r_pend[0], r_pend[1], r_pend[2], r_pend[3], r_pend[4]} : '0;
  assign mem.mem_wdata1   = w_wr ? {r_pend[5], r_pend[6], r_pend[7], r_pend[8], r_pend[9]} : '0;

  assign o_busy      = w_rd || w_wr;
  assign o_done      = (r_state == DONE);
  assign o_gen_count = r_gen;
endmodule

// File: tb/tb_life_sweep_engine.sv
// tb_life_sweep_engine: grid memory model plus generation-level Life reference
module tb_life_sweep_engine;
  localparam logic [8:0] BIRTH = 9'b000001000;
  localparam logic [8:0] SURV  = 9'b000001100;
  typedef logic [99:0][7:0] grid_t;
  typedef struct {
    logic [99:0] init_live;
    logic [99:0] exp_live;
    logic [7:0]  border;
    int          gens;
  } vec_t;

  logic clk = 0, rst_n = 0, start = 0, load = 0;
  logic busy, done;
  logic [15:0] gen_count;
  logic [168:0] mem_out;
  grid_t mem = '0, img = '0;
  int checks = 0, errors = 0, wr_cycles = 0, proto_bad = 0, exp_gen = 0;

  life_sweep_engine_if mif();
  life_sweep_engine #(.BIRTH_MASK(BIRTH), .SURVIVE_MASK(SURV)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
    .o_gen_count(gen_count), .mem(mif)
  );

  always #5 clk = ~clk;

  assign mem_out = {mif.mem_addr0, mif.mem_addr1, mif.mem_rden0, mif.mem_rden1, mif.mem_we0,
                    mif.mem_we1, mif.mem_neighbor, mif.mem_len0, mif.mem_len1,
                    mif.mem_wdata0, mif.mem_wdata1};

  function automatic logic [7:0] rd(input grid_t g, input int a);
    return (a >= 0 && a < 100) ? g[a] : 8'h00;
  endfunction

  // NeighborMode: port0 = {C, NW, N, NE, E}, port1 = {C, W, SW, S, SE}
  always_comb begin
    int a;
    a = int'(mif.mem_addr0[6:0]);
    mif.mem_rdata0 = '0;
    mif.mem_rdata1 = '0;
    if (mif.mem_neighbor) begin
      mif.mem_rdata0 = {rd(mem, a), rd(mem, a-11), rd(mem, a-10), rd(mem, a-9), rd(mem, a+1)};
      mif.mem_rdata1 = {rd(mem, a), rd(mem, a-1), rd(mem, a+9), rd(mem, a+10), rd(mem, a+11)};
    end
  end

  always @(posedge clk) begin
    if (load) mem <= img;
    else for (int k = 0; k < 5; k++) begin
      if (mif.mem_we0 && mif.mem_len0 == 2'b10 && int'(mif.mem_addr0[6:0]) + k < 100)
        mem[int'(mif.mem_addr0[6:0]) + k] <= mif.mem_wdata0[39-8*k -: 8];
      if (mif.mem_we1 && mif.mem_len1 == 2'b10 && int'(mif.mem_addr1[6:0]) + k < 100)
        mem[int'(mif.mem_addr1[6:0]) + k] <= mif.mem_wdata1[39-8*k -: 8];
    end
  end

  always @(negedge clk) begin
    if (mif.mem_we0 || mif.mem_we1) begin
      wr_cycles <= wr_cycles + 1;
      if (mif.mem_neighbor || mif.mem_rden0 || mif.mem_rden1 || !(mif.mem_we0 && mif.mem_we1) ||
          mif.mem_len0 != 2'b10 || mif.mem_len1 != 2'b10 || mif.mem_addr1 != mif.mem_addr0 + 40'd5 ||
          mif.mem_addr0[39:7] != '0 || mif.mem_addr0 % 40'd10 != 0)
        proto_bad <= proto_bad + 1;
    end else if (mif.mem_neighbor && (mif.mem_addr1 != '0 || !mif.mem_rden0 || !mif.mem_rden1))
      proto_bad <= proto_bad + 1;
    else if (!busy && mem_out != '0)
      proto_bad <= proto_bad + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic grid_t step(input grid_t g);
    grid_t n;
    int cnt;
    logic alive;
    n = g;
    for (int r = 1; r <= 8; r++)
      for (int c = 1; c <= 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) cnt += int'(g[(r+dr)*10 + c + dc][0]);
        alive = g[r*10 + c][0] ? SURV[cnt] : BIRTH[cnt];
        n[r*10 + c] = alive ? 8'h01 : 8'h00;
      end
    return n;
  endfunction

  function automatic logic is_border(input int a);
    return a < 10 || a >= 90 || a % 10 == 0 || a % 10 == 9;
  endfunction

  function automatic logic [99:0] bm(input int a0, input int a1, input int a2, input int a3, input int a4);
    logic [99:0] v;
    int l[5];
    l = '{a0, a1, a2, a3, a4};
    v = '0;
    foreach (l[i]) if (l[i] >= 0) v[l[i]] = 1'b1;
    return v;
  endfunction

  function automatic grid_t rand_grid();
    grid_t g;
    for (int a = 0; a < 100; a++)
      g[a] = is_border(a) ? 8'($urandom) : {7'($urandom), $urandom_range(0, 9) < 4};
    return g;
  endfunction

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_gen = 0;
    @(negedge clk);
  endtask

  task automatic load_grid(input grid_t g);
    img = g;
    load = 1;
    @(posedge clk);
    @(negedge clk);
    load = 0;
  endtask

  task automatic cmp_grid(input string nm, input grid_t exp);
    int bad, first;
    bad = 0;
    first = -1;
    for (int a = 0; a < 100; a++)
      if (mem[a] !== exp[a]) begin
        bad++;
        if (first < 0) first = a;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bytes differ, byte %0d got %h expected %h", nm, bad, first, mem[first], exp[first]);
    end
  endtask

  task automatic run_gen(input string nm);
    int lat, nb, w0;
    lat = 0;
    nb = 0;
    w0 = wr_cycles;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) lat = k;
    end
    chk({nm, " done latency"}, 64'(lat), 64'd73);
    chk({nm, " busy cycles"}, 64'(nb), 64'd72);
    @(negedge clk);
    exp_gen++;
    chk({nm, " gen_count"}, 64'(gen_count), 64'(exp_gen));
    chk({nm, " write cycles"}, 64'(wr_cycles - w0), 64'd8);
  endtask

  initial begin
    vec_t vecs[4];
    grid_t g, e;
    int nd;
    vecs[0] = '{bm(43, 44, 45, -1, -1), bm(34, 44, 54, -1, -1), 8'h00, 1};
    vecs[1] = '{bm(11, 12, 21, 22, -1), bm(11, 12, 21, 22, -1), 8'hA0, 1};
    vecs[2] = '{bm(0, 1, 2, -1, -1),    bm(0, 1, 2, 11, -1),    8'h00, 1};
    vecs[3] = '{bm(12, 23, 31, 32, 33), bm(23, 34, 42, 43, 44), 8'h00, 4};

    rst_n = 0;
    start = 1;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset gen_count", 64'(gen_count), 64'd0);
    chk("reset mem outputs", 64'(mem_out != '0), 64'd0);
    start = 0;
    rst_n = 1;
    @(negedge clk);
    chk("idle after reset busy", 64'(busy), 64'd0);

    foreach (vecs[i]) begin
      do_reset();
      for (int a = 0; a < 100; a++)
        g[a] = vecs[i].init_live[a] ? 8'h01 : (is_border(a) ? vecs[i].border : 8'h00);
      for (int a = 0; a < 100; a++)
        e[a] = is_border(a) ? g[a] : (vecs[i].exp_live[a] ? 8'h01 : 8'h00);
      load_grid(g);
      for (int n = 0; n < vecs[i].gens; n++) run_gen($sformatf("vec%0d gen%0d", i, n));
      cmp_grid($sformatf("vec%0d grid", i), e);
    end

    for (int t = 0; t < 6; t++) begin
      g = rand_grid();
      e = step(g);
      load_grid(g);
      run_gen($sformatf("rand%0d", t));
      cmp_grid($sformatf("rand%0d grid", t), e);
    end

    do_reset();
    g = rand_grid();
    load_grid(g);
    nd = 0;
    start = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 99) start = 0;
      if (done) nd++;
    end
    chk("held start generations", 64'(nd), 64'd2);
    chk("held start gen_count", 64'(gen_count), 64'd2);
    cmp_grid("held start grid", step(step(g)));

    do_reset();
    load_grid(rand_grid());
    run_gen("pre-abort");
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (20) @(negedge clk);
    chk("mid-sweep busy", 64'(busy), 64'd1);
    rst_n = 0;
    @(negedge clk);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort mem outputs", 64'(mem_out != '0), 64'd0);
    chk("abort gen_count", 64'(gen_count), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("protocol violations", 64'(proto_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
